// File: rtl/cache_pkg.sv
// Shared types and constants for the cache line-transfer sequencer.
package cache_pkg;

  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W       = 3;
  localparam int CACHE_ADDR_W   = 16;
  localparam int LINE_ADDR_W    = CACHE_ADDR_W - OFFSET_W;

  typedef enum logic [2:0] {
    XFER_IDLE,
    XFER_WB,
    XFER_FILL,
    XFER_DRAIN,
    XFER_DONE
  } xfer_state_t;

  // Main memory is word-interleaved: the bank is the word index within the line.
  function automatic logic [1:0] bank_of(input logic [OFFSET_W-1:0] byte_off);
    return 2'(byte_off >> 1);
  endfunction

endpackage

// File: rtl/cache_line_xfer_tag_pipe.sv
// xfer_tag_pipe: DEPTH-stage shift register of {valid, word} that marks when
// each issued memory read returns its data.
module xfer_tag_pipe #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_word,
  output logic       out_valid,
  output logic [1:0] out_word
);

  logic [DEPTH-1:0] valid_reg;
  logic [1:0]       word_reg [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
          word_reg[gi]  <= '0;
        end else begin
          valid_reg[gi] <= in_valid;
          word_reg[gi]  <= in_word;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
          word_reg[gi]  <= '0;
        end else begin
          valid_reg[gi] <= valid_reg[gi-1];
          word_reg[gi]  <= word_reg[gi-1];
        end
      end
    end
  end

  assign out_valid = valid_reg[DEPTH-1];
  assign out_word  = word_reg[DEPTH-1];

endmodule

// File: rtl/cache_line_xfer.sv
// Line-transfer sequencer: optional victim writeback, then a 4-word line fill
// with per-bank busy stalls. Macro CACHE_XFER_CRIT_WORD_FIRST_EN enables
// critical-word-first fill order and the crit_ready pulse.
module cache_line_xfer
  import cache_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       evict,
  input  logic [ADDR_W-OFFSET_W-1:0] fill_addr,
  input  logic [ADDR_W-OFFSET_W-1:0] wb_addr,
  input  logic [1:0]                 req_word,
  output logic                       ack,
  output logic                       done,
  output logic                       crit_ready,
  output logic                       c_enable,
  output logic                       c_write,
  output logic                       comp,
  output logic [OFFSET_W-1:0]        c_offset,
  output logic                       c_valid_in,
  output logic [DATA_W-1:0]          c_data_out,
  input  logic [DATA_W-1:0]          c_data_in,
  output logic [ADDR_W-1:0]          m_addr,
  output logic                       m_rd,
  output logic                       m_wr,
  output logic [DATA_W-1:0]          m_data_out,
  input  logic [DATA_W-1:0]          m_data_in,
  input  logic [3:0]                 m_busy
);

  localparam int LA_W = ADDR_W - OFFSET_W;

  xfer_state_t     state_reg, state_next;
  logic [2:0]      icnt_reg, icnt_next;
  logic [2:0]      wcnt_reg, wcnt_next;
  logic [LA_W-1:0] fill_addr_reg, wb_addr_reg;
  logic            accept;
  logic [1:0]      base_word;
  logic [1:0]      issue_word;
  logic            issue_ok;
  logic            tag_in_valid;
  logic            fill_write;
  logic [1:0]      fill_word;

  assign accept = (state_reg == XFER_IDLE) && start;

`ifdef CACHE_XFER_CRIT_WORD_FIRST_EN
  logic [1:0] req_word_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_word_reg <= '0;
    end else if (accept) begin
      req_word_reg <= req_word;
    end
  end

  assign base_word  = req_word_reg;
  assign crit_ready = fill_write && (fill_word == req_word_reg);
`else
  logic unused_req_word;
  assign unused_req_word = ^req_word;
  assign base_word       = 2'd0;
  assign crit_ready      = 1'b0;
`endif

  // Fill order rotates from base_word; writeback always walks 0..3.
  assign issue_word   = (state_reg == XFER_FILL) ? base_word + icnt_reg[1:0] : icnt_reg[1:0];
  assign issue_ok     = !m_busy[bank_of({issue_word, 1'b0})];
  assign tag_in_valid = (state_reg == XFER_FILL) && issue_ok;
  assign comp         = 1'b0;

  xfer_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (tag_in_valid),
    .in_word   (issue_word),
    .out_valid (fill_write),
    .out_word  (fill_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= XFER_IDLE;
      icnt_reg      <= '0;
      wcnt_reg      <= '0;
      fill_addr_reg <= '0;
      wb_addr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      icnt_reg  <= icnt_next;
      wcnt_reg  <= wcnt_next;
      if (accept) begin
        fill_addr_reg <= fill_addr;
        wb_addr_reg   <= wb_addr;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    icnt_next  = icnt_reg;
    wcnt_next  = fill_write ? wcnt_reg + 3'd1 : wcnt_reg;
    ack        = 1'b0;
    done       = 1'b0;
    c_enable   = 1'b0;
    c_write    = 1'b0;
    c_offset   = '0;
    c_valid_in = 1'b0;
    c_data_out = '0;
    m_addr     = '0;
    m_rd       = 1'b0;
    m_wr       = 1'b0;
    m_data_out = '0;

    case (state_reg)
      XFER_IDLE: begin
        ack = start && !rst;
        if (start) begin
          icnt_next  = '0;
          wcnt_next  = '0;
          state_next = evict ? XFER_WB : XFER_FILL;
        end
      end
      XFER_WB: begin
        if (issue_ok) begin
          c_enable   = 1'b1;
          c_offset   = {issue_word, 1'b0};
          m_wr       = 1'b1;
          m_addr     = {wb_addr_reg, issue_word, 1'b0};
          m_data_out = c_data_in;
          if (icnt_reg == 3'(WORDS_PER_LINE - 1)) begin
            icnt_next  = '0;
            state_next = XFER_FILL;
          end else begin
            icnt_next = icnt_reg + 3'd1;
          end
        end
      end
      XFER_FILL: begin
        if (issue_ok) begin
          m_rd      = 1'b1;
          m_addr    = {fill_addr_reg, issue_word, 1'b0};
          icnt_next = icnt_reg + 3'd1;
          if (icnt_reg == 3'(WORDS_PER_LINE - 1)) begin
            state_next = XFER_DRAIN;
          end
        end
      end
      XFER_DRAIN: begin
        if (fill_write && (wcnt_reg == 3'(WORDS_PER_LINE - 1))) begin
          state_next = XFER_DONE;
        end
      end
      XFER_DONE: begin
        done       = 1'b1;
        state_next = XFER_IDLE;
      end
      default: state_next = XFER_IDLE;
    endcase

    // Returning read data lands in the cache; never coincides with a writeback.
    if (fill_write) begin
      c_enable   = 1'b1;
      c_write    = 1'b1;
      c_valid_in = 1'b1;
      c_offset   = {fill_word, 1'b0};
      c_data_out = m_data_in;
    end
  end

endmodule
